adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched.sv | 124 ++++++++++++
 tb/tb_adder_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sched.sv
// Round-robin arbitrated two-stage pipeline computing 2*a + b for NREQ requesters.
// A stalled response freezes both stages and withholds every grant.
`timescale 1ns/1ps
module adder_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16,
    localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic [IdW-1:0]      rsp_id,
    output logic                busy,
    output logic [15:0]         done_count
);

    logic           s1_valid_q, s1_valid_d;
    logic [W-1:0]   s1_a_q, s1_a_d;
    logic [W-1:0]   s1_b_q, s1_b_d;
    logic [IdW-1:0] s1_id_q, s1_id_d;

    logic           s2_valid_q, s2_valid_d;
    logic [W-1:0]   s2_data_q, s2_data_d;
    logic [IdW-1:0] s2_id_q, s2_id_d;

    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]    done_count_q, done_count_d;

    logic           advance;
    logic           grant_found;
    logic [IdW-1:0] grant_idx;
    logic [IdW-1:0] cand;
    logic           accept;
    logic [W-1:0]   result;

    assign advance = !s2_valid_q || rsp_ready;

    // First requester with valid high, scanning upward from rr_ptr with wraparound.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IdW'((32'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // rst_n gates the grant so nothing is offered while reset is held.
    assign accept    = advance && grant_found && rst_n;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    assign result = (s1_a_q << 1) + s1_b_q;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_id_d      = s2_id_q;
        rr_ptr_d     = rr_ptr_q;
        done_count_d = done_count_q;

        if (advance) begin
            s1_valid_d = accept;
            s2_valid_d = s1_valid_q;
            s2_data_d  = result;
            s2_id_d    = s1_id_q;
        end

        if (accept) begin
            s1_a_d   = req_a[32'(grant_idx)*W +: W];
            s1_b_d   = req_b[32'(grant_idx)*W +: W];
            s1_id_d  = grant_idx;
            rr_ptr_d = IdW'((32'(grant_idx) + 1) % NREQ);
        end

        if (s2_valid_q && rsp_ready) begin
            done_count_d = done_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_id_q      <= '0;
            rr_ptr_q     <= '0;
            done_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_id_q      <= s2_id_d;
            rr_ptr_q     <= rr_ptr_d;
            done_count_q <= done_count_d;
        end
    end

    assign rsp_valid  = s2_valid_q;
    assign rsp_data   = s2_data_q;
    assign rsp_id     = s2_id_q;
    assign busy       = s1_valid_q || s2_valid_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_adder_sched.sv
// Randomised scoreboard bench for adder_sched: a driver predicts grants and pushes
// expected results, a separate monitor pops them on every response handshake.
`timescale 1ns/1ps
module tb_adder_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [W-1:0]      rsp_data;
    logic [1:0]        rsp_id;
    logic              busy;
    logic [15:0]       done_count;

    adder_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          id;
    } exp_t;

    exp_t        sb[$];
    bit          line[$];   // occupancy of the two pipeline slots, [1] is the output slot
    int          m_rr;
    int unsigned m_total;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_rr    = 0;
        m_total = 0;
        sb.delete();
        line.delete();
        line.push_back(1'b0);
        line.push_back(1'b0);
    endtask

    // Predict this cycle's outputs, then advance the model across the coming edge.
    task automatic evaluate();
        bit          out_v;
        bit          adv;
        int          w;
        int          idx;
        int unsigned aa;
        int unsigned bb;
        logic [3:0]  exp_ready;
        out_v = line[1];
        adv   = !out_v || rsp_ready;
        w     = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (w < 0 && req_valid[idx]) w = idx;
        end
        exp_ready = (adv && w >= 0) ? 4'(1 << w) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(out_v));
        chk("busy", 32'(busy), 32'(line[0] || line[1]));
        chk("done_count", 32'(done_count), m_total % 65536);
        if (out_v && rsp_ready) m_total++;
        if (adv) begin
            if (w >= 0) begin
                aa = 32'(req_a[w*W +: W]);
                bb = 32'(req_b[w*W +: W]);
                sb.push_back('{d: 16'((2 * aa + bb) % 65536), id: w});
                m_rr = (w + 1) % NREQ;
            end
            line.push_front(w >= 0);
            void'(line.pop_back());
        end
    endtask

    task automatic step(input logic [3:0] rv, input logic [63:0] av, input logic [63:0] bv,
                        input logic rr);
        req_valid = rv;
        req_a     = av;
        req_b     = bv;
        rsp_ready = rr;
        @(negedge clk);
        evaluate();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_in_reset(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done_count"}, 32'(done_count), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
    endtask

    // Asserts reset from posedge+1, holds it across one edge, releases on a negedge.
    task automatic do_reset(input string tag);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_in_reset(tag);
        @(posedge clk);
        #1;
        check_in_reset(tag);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 64'h0, 64'h0, 1'b1);
    endtask

    // Monitor: pops the scoreboard on each response handshake, checks stall stability.
    initial begin
        logic [15:0] held_d;
        logic [1:0]  held_id;
        bit          held;
        exp_t        e;
        held = 0;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (held) begin
                    chk("hold_data", 32'(rsp_data), 32'(held_d));
                    chk("hold_id", 32'(rsp_id), 32'(held_id));
                end
                if (rsp_ready) begin
                    held = 0;
                    n_checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL rsp_unexpected: got data 0x%0h id %0d, expected no response",
                                 rsp_data, rsp_id);
                    end else begin
                        n_pass++;
                        e = sb.pop_front();
                        chk("rsp_data", 32'(rsp_data), 32'(e.d));
                        chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    end
                end else begin
                    held    = 1;
                    held_d  = rsp_data;
                    held_id = rsp_id;
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset("por");

        // Single op: 2*3 + 4 = 10 from requester 0.
        step(4'b0001, 64'h3, 64'h4, 1'b1);
        drain(3);
        chk("single_done_count", 32'(done_count), 1);

        // Truncation: 0x8000*2+5 -> 0x0005, 0xFFFF*2+2 -> 0x0000.
        step(4'b0001, 64'h8000, 64'h5, 1'b1);
        step(4'b0001, 64'hFFFF, 64'h2, 1'b1);
        drain(3);

        // Fairness with all requesters active.
        for (int i = 0; i < 8; i++) step(4'b1111, rnd64(), rnd64(), 1'b1);
        drain(3);

        // Backpressure: five stalled cycles then resume.
        step(4'b1111, rnd64(), rnd64(), 1'b1);
        step(4'b1111, rnd64(), rnd64(), 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1111, rnd64(), rnd64(), 1'b0);
        for (int i = 0; i < 4; i++) step(4'b1111, rnd64(), rnd64(), 1'b1);
        drain(4);
        chk("bp_sb_empty", 32'(sb.size()), 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            step(4'($urandom), rnd64(), rnd64(), 1'($urandom_range(0, 9) < 7));
        end
        drain(6);
        chk("rand_sb_empty", 32'(sb.size()), 0);

        // Reset with two operations in flight; no stale response afterwards.
        step(4'b0001, 64'h5, 64'h1, 1'b1);
        step(4'b0010, 64'h50000, 64'h10000, 1'b0);
        do_reset("mid");
        drain(4);
        for (int i = 0; i < 6; i++) step(4'b1111, rnd64(), rnd64(), 1'b1);
        drain(4);
        chk("mid_sb_empty", 32'(sb.size()), 0);

        // Counter wrap after 65536 completed responses.
        do_reset("wrap");
        while (m_total < 65536) step(4'b1111, rnd64(), rnd64(), 1'b1);
        chk("done_wrap", 32'(done_count), 0);
        drain(4);
        chk("wrap_sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
